// File: rtl/rs232_pkg.sv
// Shared constants and state types for the RS-232 Avalon-MM slave.
// RS232_PARITY_EN adds an even-parity bit to every frame (8E1).
package rs232_pkg;

    localparam logic [1:0] ADDR_RX_DATA = 2'd0;
    localparam logic [1:0] ADDR_TX_DATA = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;

    localparam int ST_RX_VALID   = 7;
    localparam int ST_TX_READY   = 6;
    localparam int ST_OVERRUN    = 5;
    localparam int ST_FRAME_ERR  = 4;
    localparam int ST_PARITY_ERR = 3;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/rs232_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM, 1-cycle result pulses.
// RS232_PARITY_EN makes it expect and check an even-parity bit before STOP.
module rs232_rx
    import rs232_pkg::*;
#(
    parameter int CLK_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd_i,
    output logic       byte_done_o,
    output logic [7:0] byte_o,
    output logic       frame_err_o,
    output logic       parity_err_o
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_PER_BIT / 2 - 1);

    logic            sync1_q, sync2_q, prev_q;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sh_q, sh_d;
    logic            tick;
`ifdef RS232_PARITY_EN
    logic            par_q, par_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
`ifdef RS232_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            sync1_q <= rxd_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
`ifdef RS232_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tick   = (cnt_q == '0);
    assign byte_o = sh_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = tick ? cnt_q : cnt_q - CW'(1);
        bit_d        = bit_q;
        sh_d         = sh_q;
        byte_done_o  = 1'b0;
        frame_err_o  = 1'b0;
        parity_err_o = 1'b0;
`ifdef RS232_PARITY_EN
        par_d        = par_q;
`endif
        unique case (state_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                    cnt_d   = HALF;
                end
            end
            RX_START: begin
                // A line that is high again at mid start bit was a glitch
                if (tick) begin
                    if (sync2_q) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                        cnt_d   = FULL;
                        bit_d   = '0;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    sh_d  = {sync2_q, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    cnt_d = FULL;
                    if (bit_q == 3'd7) begin
`ifdef RS232_PARITY_EN
                        state_d = RX_PARITY;
`else
                        state_d = RX_STOP;
`endif
                    end
                end
            end
            RX_PARITY: begin
`ifdef RS232_PARITY_EN
                if (tick) begin
                    par_d   = sync2_q;
                    cnt_d   = FULL;
                    state_d = RX_STOP;
                end
`else
                state_d = RX_IDLE;
`endif
            end
            RX_STOP: begin
                if (tick) begin
                    state_d = RX_IDLE;
                    if (!sync2_q) begin
                        frame_err_o = 1'b1;
`ifdef RS232_PARITY_EN
                    end else if (par_q != ^sh_q) begin
                        parity_err_o = 1'b1;
`endif
                    end else begin
                        byte_done_o = 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/rs232_avm_slave.sv
// Avalon-MM slave with RX/TX/STATUS registers and an 8N1 UART.
// RS232_PARITY_EN switches the serial format to 8E1 and enables STATUS bit3.
module rs232_avm_slave
    import rs232_pkg::*;
#(
    parameter int CLK_PER_BIT = 434
) (
    input  logic        avm_clk,
    input  logic        avm_rst,
    input  logic [4:0]  avm_address,
    input  logic        avm_read,
    output logic [31:0] avm_readdata,
    input  logic        avm_write,
    input  logic [31:0] avm_writedata,
    output logic        avm_waitrequest,
    input  logic        uart_rxd,
    output logic        uart_txd
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLK_PER_BIT - 1);

    logic [1:0]    reg_sel;
    logic          rd_first, rd_acc, rx_rd, tx_wr;
    logic          rd_done_q;
    logic [31:0]   rdata_q, rdata_d;

    logic          rx_done, rx_ferr, rx_perr;
    logic [7:0]    rx_byte;
    logic [7:0]    rx_data_q;
    logic          rx_valid_q, overrun_q, frame_err_q;
    logic          parity_flag;

    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_sh_q, tx_sh_d;
    logic          tx_par_q, tx_par_d;
    logic          tx_pend_q, tx_pend_d;
    logic          tx_tick, tx_ready;

    logic          unused_ok;
    assign unused_ok = ^{avm_address[4], avm_address[1:0],
                         avm_writedata[31:8], rx_perr};

    assign reg_sel  = avm_address[3:2];
    assign rd_first = avm_read && !rd_done_q;
    assign rd_acc   = avm_read && rd_done_q;
    assign rx_rd    = rd_acc && (reg_sel == ADDR_RX_DATA);
    assign tx_wr    = avm_write && !avm_read && (reg_sel == ADDR_TX_DATA);

    assign avm_waitrequest = rd_first;
    assign avm_readdata    = rdata_q;
    assign tx_ready        = (tx_state_q == TX_IDLE);

    rs232_rx #(
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_rx (
        .clk          (avm_clk),
        .rst          (avm_rst),
        .rxd_i        (uart_rxd),
        .byte_done_o  (rx_done),
        .byte_o       (rx_byte),
        .frame_err_o  (rx_ferr),
        .parity_err_o (rx_perr)
    );

    always_comb begin
        rdata_d = '0;
        unique case (reg_sel)
            ADDR_RX_DATA: rdata_d[7:0] = rx_data_q;
            ADDR_STATUS: begin
                rdata_d[ST_RX_VALID]   = rx_valid_q;
                rdata_d[ST_TX_READY]   = tx_ready;
                rdata_d[ST_OVERRUN]    = overrun_q;
                rdata_d[ST_FRAME_ERR]  = frame_err_q;
                rdata_d[ST_PARITY_ERR] = parity_flag;
            end
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            rd_done_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rd_done_q <= rd_first;
            if (rd_first) rdata_q <= rdata_d;
        end
    end

    // A byte landing with an accepted RX_DATA read replaces the one being read
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (rx_rd) begin
                rx_valid_q  <= 1'b0;
                overrun_q   <= 1'b0;
                frame_err_q <= 1'b0;
            end
            if (rx_done) begin
                if (!rx_valid_q || rx_rd) begin
                    rx_data_q  <= rx_byte;
                    rx_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
            if (rx_ferr) frame_err_q <= 1'b1;
        end
    end

`ifdef RS232_PARITY_EN
    logic parity_err_q;
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            parity_err_q <= 1'b0;
        end else if (rx_perr) begin
            parity_err_q <= 1'b1;
        end else if (rx_rd) begin
            parity_err_q <= 1'b0;
        end
    end
    assign parity_flag = parity_err_q;
`else
    assign parity_flag = 1'b0;
`endif

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_par_q   <= 1'b0;
            tx_pend_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_par_q   <= tx_par_d;
            tx_pend_q  <= tx_pend_d;
        end
    end

    assign tx_tick = (tx_cnt_q == '0);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_tick ? tx_cnt_q : tx_cnt_q - CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        tx_pend_d  = tx_pend_q;
        uart_txd   = 1'b1;
        // Accepted byte waits one cycle in the buffer before START begins
        if (tx_wr && tx_ready && !tx_pend_q) begin
            tx_pend_d = 1'b1;
            tx_sh_d   = avm_writedata[7:0];
            tx_par_d  = ^avm_writedata[7:0];
        end
        unique case (tx_state_q)
            TX_IDLE: begin
                if (tx_pend_q) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = FULL;
                    tx_pend_d  = 1'b0;
                end
            end
            TX_START: begin
                uart_txd = 1'b0;
                if (tx_tick) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = FULL;
                    tx_bit_d   = '0;
                end
            end
            TX_DATA: begin
                uart_txd = tx_sh_q[0];
                if (tx_tick) begin
                    tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                    tx_bit_d = tx_bit_q + 3'd1;
                    tx_cnt_d = FULL;
                    if (tx_bit_q == 3'd7) begin
`ifdef RS232_PARITY_EN
                        tx_state_d = TX_PARITY;
`else
                        tx_state_d = TX_STOP;
`endif
                    end
                end
            end
            TX_PARITY: begin
                uart_txd = tx_par_q;
                if (tx_tick) begin
                    tx_state_d = TX_STOP;
                    tx_cnt_d   = FULL;
                end
            end
            TX_STOP: begin
                if (tx_tick) tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

endmodule
